// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: the 128-bit block type, rotate helpers, and the
// forward and inverse linear transforms.
// The inverse transform is split into two halves so it can be pipelined.
// Word packing: x0 = [127:96], x1 = [95:64], x2 = [63:32], x3 = [31:0].
package serpent_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t x0;
    word_t x1;
    word_t x2;
    word_t x3;
  } block_t;

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t rol(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Forward linear transform used on the encryption side.
  function automatic block_t lt_fwd(input block_t b);
    block_t t;
    t    = b;
    t.x0 = rol(t.x0, 13);
    t.x2 = rol(t.x2, 3);
    t.x1 = t.x1 ^ t.x0 ^ t.x2;
    t.x3 = t.x3 ^ t.x2 ^ (t.x0 << 3);
    t.x1 = rol(t.x1, 1);
    t.x3 = rol(t.x3, 7);
    t.x0 = t.x0 ^ t.x1 ^ t.x3;
    t.x2 = t.x2 ^ t.x3 ^ (t.x1 << 7);
    t.x0 = rol(t.x0, 5);
    t.x2 = rol(t.x2, 22);
    return t;
  endfunction

  // First half of the inverse: undoes the last four forward steps.
  function automatic block_t inv_lt_s1(input block_t b);
    block_t t;
    t    = b;
    t.x2 = ror(t.x2, 22);
    t.x0 = ror(t.x0, 5);
    t.x2 = t.x2 ^ t.x3 ^ (t.x1 << 7);
    t.x0 = t.x0 ^ t.x1 ^ t.x3;
    return t;
  endfunction

  // Second half of the inverse: undoes the first six forward steps.
  function automatic block_t inv_lt_s2(input block_t b);
    block_t t;
    t    = b;
    t.x3 = ror(t.x3, 7);
    t.x1 = ror(t.x1, 1);
    t.x3 = t.x3 ^ t.x2 ^ (t.x0 << 3);
    t.x1 = t.x1 ^ t.x0 ^ t.x2;
    t.x2 = ror(t.x2, 3);
    t.x0 = ror(t.x0, 13);
    return t;
  endfunction

  function automatic block_t inv_lt(input block_t b);
    return inv_lt_s2(inv_lt_s1(b));
  endfunction

endpackage

// File: rtl/serpent_pipe_stage.sv
// One pipeline stage: a data register plus its valid flag.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : synchronous flush of the valid flag
//   i_load         : a new block enters this stage
//   i_drop         : the held block leaves this stage (ignored when i_load)
//   i_data         : block to capture on i_load
//   o_valid/o_data : registered valid flag and block
module serpent_pipe_stage
  import serpent_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clear,
  input  logic   i_load,
  input  logic   i_drop,
  input  block_t i_data,
  output logic   o_valid,
  output block_t o_data
);

  logic   vld_d, vld_q;
  block_t data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (i_clear) begin
      vld_d = 1'b0;
    end else if (i_load) begin
      vld_d = 1'b1;
    end else if (i_drop) begin
      vld_d = 1'b0;
    end
    // Data only moves on a real load; a flush leaves the register untouched.
    if (i_load && !i_clear) begin
      data_d = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign o_valid = vld_q;
  assign o_data  = data_q;

endmodule

// File: rtl/serpent_inv_lt.sv
// Serpent inverse linear transform as a two-stage valid/ready pipeline.
// Stage 1 registers the first half of InvLT, stage 2 the second half.
// Ports:
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_clear           : synchronous flush of both stages
//   i_valid/o_ready   : input handshake, i_data is the 128-bit block
//   o_valid/i_ready   : output handshake, o_data is the InvLT result
module serpent_inv_lt
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
);

  logic   s1_vld, s2_vld;
  block_t s1_data, s2_data;
  logic   s2_load, in_fire, out_fire;

  // Stage 2 can take a block when it is empty or its block leaves this cycle;
  // o_ready follows i_ready combinationally so a full pipe streams without a bubble.
  assign s2_load  = s1_vld && (!s2_vld || i_ready);
  assign o_ready  = !s1_vld || !s2_vld || i_ready;
  assign in_fire  = i_valid && o_ready;
  assign out_fire = s2_vld && i_ready;

  serpent_pipe_stage u_s1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_load  (in_fire),
    .i_drop  (s2_load),
    .i_data  (inv_lt_s1(block_t'(i_data))),
    .o_valid (s1_vld),
    .o_data  (s1_data)
  );

  serpent_pipe_stage u_s2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_load  (s2_load),
    .i_drop  (out_fire),
    .i_data  (inv_lt_s2(s1_data)),
    .o_valid (s2_vld),
    .o_data  (s2_data)
  );

  assign o_valid = s2_vld;
  assign o_data  = s2_data;

endmodule

// File: tb/tb_serpent_inv_lt.sv
module tb_serpent_inv_lt;
  import serpent_pkg::*;

  logic         i_clk   = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_clear = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [127:0] i_data  = '0;
  logic         o_ready;
  logic         o_valid;
  logic [127:0] o_data;

  serpent_inv_lt dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a queue of blocks in flight (accepted, not yet
  // delivered) with the edge at which each was accepted. Capacity is two.
  typedef struct {
    logic [127:0] data;
    int           acc;
  } inflight_t;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  inflight_t    q[$];
  vec_t         vecs[5];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: drive inputs, check outputs against the model,
  // advance one rising edge, update the model, return at the next falling edge.
  task automatic step(input logic v, input logic [127:0] d, input logic [127:0] e,
                      input logic r, input logic clr, output logic acc);
    logic exp_rdy, exp_vld, out_fire;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_clear = clr;
    #1;
    exp_rdy = (q.size() < 2) || r;
    exp_vld = (q.size() > 0) && (q[0].acc < cyc);
    check("o_ready", {127'b0, o_ready}, {127'b0, exp_rdy});
    check("o_valid", {127'b0, o_valid}, {127'b0, exp_vld});
    if (prev_stall) check("stall_hold", o_data, prev_data);
    out_fire = exp_vld && r;
    if (out_fire) check("o_data", o_data, q[0].data);
    acc        = v && exp_rdy && !clr;
    prev_stall = exp_vld && !r && !clr;
    prev_data  = o_data;
    @(posedge i_clk);
    cyc++;
    if (out_fire) void'(q.pop_front());
    if (clr) q.delete();
    else if (acc) q.push_back('{e, cyc});
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  task automatic fill_two();
    logic   acc;
    block_t b;
    for (int i = 0; i < 2; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, lt_fwd(b), b, 1'b0, 1'b0, acc);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic   acc;
    block_t b;
    block_t bp[8];
    int     k;
    int     got;

    vecs[0] = '{128'h0, 128'h0};
    vecs[1] = '{128'h00000000_00000000_00000000_00000001, 128'h00080000_00000000_20000000_02000009};
    vecs[2] = '{128'h00000001_00000000_00000000_00000000, 128'h00004000_08000000_00000000_40000000};
    vecs[3] = '{128'h00000000_00000001_00000000_00000000, 128'h00080000_80000081_00000010_00000088};
    vecs[4] = '{128'h00000000_00000000_00000001_00000000, 128'h00000000_00000400_00000080_00000400};

    // Reset values
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_o_valid", {127'b0, o_valid}, 128'd0);
    check("rst_o_ready", {127'b0, o_ready}, 128'd1);
    check("rst_o_data", o_data, 128'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Known vectors, one beat each with idle gaps
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vecs[i].din, vecs[i].exp, 1'b1, 1'b0, acc);
      idle(3);
    end
    // All-ones vector
    step(1'b1, {128{1'b1}}, 128'hFFFFFFFF_FFFFFF80_1FFFFFF0_FFFFFF87, 1'b1, 1'b0, acc);
    idle(3);

    // Round-trip streaming at full rate
    for (int i = 0; i < 1000; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, lt_fwd(b), b, 1'b1, 1'b0, acc);
    end
    idle(4);

    // Backpressure: i_ready low for the first 5 cycles of an 8-block stream
    for (int i = 0; i < 8; i++) bp[i] = {$urandom, $urandom, $urandom, $urandom};
    k = 0;
    for (int c = 0; c < 40 && (k < 8 || q.size() > 0); c++) begin
      b = bp[(k < 8) ? k : 0];
      step(k < 8, lt_fwd(b), b, c >= 5, 1'b0, acc);
      if (acc) k++;
    end
    idle(2);

    // Random valid/ready toggling
    got = 0;
    for (int c = 0; c < 12000 && got < 2000; c++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), lt_fwd(b), b, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) got++;
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) idle(1);

    // Clear with both stages full, stalled output, new input offered
    fill_two();
    b = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, lt_fwd(b), b, 1'b0, 1'b1, acc);
    idle(5);

    // Clear coinciding with an output fire
    fill_two();
    b = {$urandom, $urandom, $urandom, $urandom};
    step(1'b1, lt_fwd(b), b, 1'b1, 1'b1, acc);
    idle(5);

    // Asynchronous reset mid-stream
    fill_two();
    i_valid = 1'b1;
    i_ready = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_o_valid", {127'b0, o_valid}, 128'd0);
    check("arst_o_ready", {127'b0, o_ready}, 128'd1);
    check("arst_o_data", o_data, 128'h0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(5);

    // Traffic after reset still flows correctly
    for (int i = 0; i < 20; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, lt_fwd(b), b, 1'($urandom_range(0, 1)), 1'b0, acc);
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
